// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_BUF_EN to put a 4-entry byte FIFO ahead of the shifter.
module uart_tx #(
  parameter int BR_DIV    = 868,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       txd,
  output logic       busy,
  output logic       tx_done,
  output logic [2:0] state_dbg
);

  // Handshake: a byte moves when din_valid && din_ready on a rising clk edge;
  // the producer holds din/din_valid stable until that happens.

  localparam int CW = (BR_DIV > 2) ? $clog2(BR_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  if (BR_DIV < 2) begin : g_bad_div
    $error("uart_tx: BR_DIV must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic          bit_tick;
  logic [7:0]    shift;
  logic          par_bit;
  logic [2:0]    bit_idx;
  logic          stop_cnt;
  logic          stop_last;
  logic          load;
  logic [7:0]    load_byte;

  function automatic logic par_of(input logic [7:0] b);
    return (PARITY == 2) ? ~^b : ^b;
  endfunction

  assign bit_tick  = (baud_cnt == CW'(BR_DIV - 1));
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  assign state_dbg = state;

`ifdef UART_TX_BUF_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_cnt;
  logic       fifo_empty;
  logic       push;

  assign fifo_empty = (fifo_cnt == 3'd0);
  assign din_ready  = !rst && (fifo_cnt != 3'd4);
  assign push       = din_valid && din_ready;
  // Pop straight out of the last stop bit so consecutive frames abut.
  assign load       = !fifo_empty &&
                      ((state == S_IDLE) || (state == S_STOP && bit_tick && stop_last));
  assign load_byte  = fifo_mem[rd_ptr];
  assign busy       = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (load) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(load);
    end
  end
`else
  assign din_ready = !rst && (state == S_IDLE);
  assign load      = din_valid && din_ready;
  assign load_byte = din;
  assign busy      = (state != S_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      txd      <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      // Clearing on load makes every bit, including the first, exactly BR_DIV clocks.
      if (load) baud_cnt <= '0;
      else if (state != S_IDLE) baud_cnt <= bit_tick ? '0 : baud_cnt + CW'(1);

      case (state)
        S_IDLE: begin
          if (load) begin
            state   <= S_START;
            txd     <= 1'b0;
            shift   <= load_byte;
            par_bit <= par_of(load_byte);
          end
        end
        S_START: begin
          if (bit_tick) begin
            state   <= S_DATA;
            bit_idx <= '0;
            txd     <= shift[0];
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              if (PARITY != 0) begin
                state <= S_PAR;
                txd   <= par_bit;
              end else begin
                state    <= S_STOP;
                stop_cnt <= 1'b0;
                txd      <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[1];
            end
          end
        end
        S_PAR: begin
          if (bit_tick) begin
            state    <= S_STOP;
            stop_cnt <= 1'b0;
            txd      <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            if (!stop_last) begin
              stop_cnt <= 1'b1;
            end else begin
              tx_done <= 1'b1;
              if (load) begin
                state   <= S_START;
                txd     <= 1'b0;
                shift   <= load_byte;
                par_bit <= par_of(load_byte);
              end else begin
                state <= S_IDLE;
                txd   <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity, even, odd, two stop bits) at BR_DIV=16,
// per-instance serial monitors decode txd and pop expected bytes from a scoreboard queue.
module tb_uart_tx;

  localparam int BR = 16;
  localparam int NI = 4;
  localparam int PAR_A  [NI] = '{0, 1, 2, 0};
  localparam int STOP_A [NI] = '{1, 1, 1, 2};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    din = 8'h00;
  logic [NI-1:0] valid = '0;
  logic [NI-1:0] rdy;
  logic [NI-1:0] txd;
  logic [NI-1:0] busy;
  logic [NI-1:0] done;
  logic [2:0]    st_dbg [NI];

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q [NI][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx #(
      .BR_DIV   (BR),
      .PARITY   (PAR_A[g]),
      .STOP_BITS(STOP_A[g])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .din_valid(valid[g]),
      .din_ready(rdy[g]),
      .txd      (txd[g]),
      .busy     (busy[g]),
      .tx_done  (done[g]),
      .state_dbg(st_dbg[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Wait n falling edges; flag an abort if reset is seen along the way.
  task automatic skip(input int n, inout logic ab);
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // Serial monitor: samples mid-bit, checks framing, compares byte+parity with the queue.
  for (genvar g = 0; g < NI; g++) begin : g_mon
    initial begin : mon
      logic       ab;
      logic       start_ok;
      logic       stop_ok;
      logic [8:0] got;
      logic [8:0] e;
      forever begin
        @(negedge clk);
        if (!rst && txd[g] === 1'b0) begin
          ab      = 1'b0;
          got     = '0;
          stop_ok = 1'b1;
          skip(BR / 2 - 1, ab);
          start_ok = (txd[g] === 1'b0);
          for (int i = 0; i < 8; i++) begin
            skip(BR, ab);
            got[i] = txd[g];
          end
          if (PAR_A[g] != 0) begin
            skip(BR, ab);
            got[8] = txd[g];
          end
          for (int s = 0; s < STOP_A[g]; s++) begin
            skip(BR, ab);
            if (txd[g] !== 1'b1) stop_ok = 1'b0;
          end
          if (!ab) begin
            check($sformatf("framing_%0d", g), 32'({start_ok, stop_ok}), 32'd3);
            if (exp_q[g].size() == 0) begin
              tests++;
              fails++;
              $display("FAIL sb_unexpected_%0d: got frame 0x%0h, expected no frame", g, got);
            end else begin
              e = exp_q[g].pop_front();
              check($sformatf("rx_byte_%0d", g), 32'(got), 32'(e));
            end
          end
        end
      end
    end
  end

  task automatic send(input int k, input logic [7:0] b, input logic p, input logic track);
    int n = 0;
    @(negedge clk);
    din      = b;
    valid[k] = 1'b1;
    while (rdy[k] !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      tests++;
      fails++;
      $display("FAIL send_timeout_%0d: din_ready never rose, expected it within 5000 clk", k);
    end
    if (track) exp_q[k].push_back({p, b});
    @(posedge clk);
    #1;
    valid[k] = 1'b0;
  endtask

  // Count busy cycles of one frame, then check the tx_done pulse that follows it.
  task automatic frame_watch(input int k, input int exp_len);
    int n = 0;
    int viol = 0;
    @(negedge clk);
    while (busy[k] === 1'b1 && n < 5000) begin
      if (rdy[k] !== 1'b0) viol++;
      n++;
      @(negedge clk);
    end
    check($sformatf("frame_len_%0d", k), 32'(n), 32'(exp_len));
    check($sformatf("ready_while_busy_%0d", k), 32'(viol), 32'd0);
    check($sformatf("tx_done_pulse_%0d", k), 32'(done[k]), 32'd1);
    @(negedge clk);
    check($sformatf("tx_done_clear_%0d", k), 32'(done[k]), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 32'(txd), 32'hF);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(rdy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(rdy), 32'hF);

`ifdef UART_TX_BUF_EN
    begin : buf_test
      logic [7:0] bytes [5];
      int n_busy;
      int n_done;
      int rose;
      bytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      n_busy = 0;
      n_done = 0;
      rose   = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (busy[0]) n_busy++;
        check($sformatf("buf_ready_%0d", i), 32'(rdy[0]), 32'd1);
        din      = bytes[i];
        valid[0] = 1'b1;
        exp_q[0].push_back({1'b0, bytes[i]});
      end
      @(negedge clk);
      valid[0] = 1'b0;
      check("buf_full_ready", 32'(rdy[0]), 32'd0);
      for (int c = 0; c < 5000; c++) begin
        if (done[0]) n_done++;
        if (rdy[0]) rose = 1;
        if (!busy[0]) break;
        n_busy++;
        @(negedge clk);
      end
      check("buf_busy_len", 32'(n_busy), 32'd801);
      check("buf_done_count", 32'(n_done), 32'd5);
      check("buf_ready_rose", 32'(rose), 32'd1);
    end
`else
    send(0, 8'h55, 1'b0, 1'b1);
    frame_watch(0, 160);
    send(1, 8'h07, 1'b1, 1'b1);
    frame_watch(1, 176);
    send(2, 8'h07, 1'b0, 1'b1);
    frame_watch(2, 176);
    send(3, 8'hA3, 1'b0, 1'b1);
    frame_watch(3, 176);

    // Back-to-back with din_valid held across the frame boundary.
    send(0, 8'h00, 1'b0, 1'b1);
    din      = 8'hFF;
    valid[0] = 1'b1;
    exp_q[0].push_back({1'b0, 8'hFF});
    frame_watch(0, 160);
    check("b2b_gap_txd", 32'(txd[0]), 32'd0);
    check("b2b_gap_busy", 32'(busy[0]), 32'd1);
    valid[0] = 1'b0;
    frame_watch(0, 159);

    // Reset in the middle of a frame.
    begin : rst_test
      int n;
      send(0, 8'h3C, 1'b0, 1'b0);
      repeat (49) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_txd", 32'(txd[0]), 32'd1);
      check("midrst_busy", 32'(busy[0]), 32'd0);
      check("midrst_done", 32'(done[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n   = 0;
      repeat (20) begin
        @(negedge clk);
        if (done[0]) n++;
      end
      check("midrst_no_done", 32'(n), 32'd0);
      check("midrst_ready", 32'(rdy[0]), 32'd1);
    end
    send(0, 8'hC9, 1'b0, 1'b1);
    frame_watch(0, 160);
`endif

    repeat (20) @(negedge clk);
    for (int k = 0; k < NI; k++) check($sformatf("sb_drain_%0d", k), 32'(exp_q[k].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
